// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage: next-PC generation, synchronous ROM addressing,
// PC/instruction alignment for decode, stall/redirect handling and fetch-fault latching.
module if_fetch_stage #(
  parameter int          DEPTH_LOG = 9,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic                 clk,
  input  logic                 resetb,
  input  logic                 stall_i,
  input  logic                 redirect_i,
  input  logic [31:0]          redirect_pc_i,
  output logic [DEPTH_LOG-1:0] rom_addr_o,
  input  logic [31:0]          rom_data_i,
  output logic                 if_valid_o,
  output logic [31:0]          if_pc_o,
  output logic [31:0]          if_instr_o,
  output logic                 fault_o,
  output logic [31:0]          fault_pc_o,
  output logic [1:0]           dbg_state_o
);

  // Handshake: decode asserts stall_i while it cannot accept if_instr_o/if_pc_o;
  // this block then holds if_valid_o/if_pc_o/if_instr_o stable. redirect_i wins over stall_i.
  typedef enum logic [1:0] {
    ST_PRIME = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } st_t;

  st_t         st;
  logic [31:0] pc_q;
  logic [31:0] next_pc;
  logic        bad;

  always_comb begin
    next_pc = pc_q;
    if (redirect_i) begin
      next_pc = redirect_pc_i;
    end else if (st == ST_RUN && !stall_i) begin
      next_pc = pc_q + 32'd4;
    end
  end

  assign bad = (next_pc[1:0] != 2'b00) || (next_pc[31:DEPTH_LOG+2] != '0);

  // Held at RESET_PC during reset so the ROM already holds the first word on release.
  assign rom_addr_o  = resetb ? next_pc[DEPTH_LOG+1:2] : RESET_PC[DEPTH_LOG+1:2];
  assign if_pc_o     = pc_q;
  assign if_instr_o  = rom_data_i;
  assign dbg_state_o = st;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      st         <= ST_PRIME;
      pc_q       <= RESET_PC;
      if_valid_o <= 1'b0;
      fault_o    <= 1'b0;
      fault_pc_o <= 32'h0;
    end else if (redirect_i) begin
      if (!bad) begin
        st         <= ST_RUN;
        pc_q       <= redirect_pc_i;
        if_valid_o <= 1'b1;
        fault_o    <= 1'b0;
      end else begin
        st         <= ST_FAULT;
        if_valid_o <= 1'b0;
        fault_o    <= 1'b1;
        fault_pc_o <= next_pc;
      end
    end else begin
      case (st)
        ST_PRIME: begin
          st         <= ST_RUN;
          if_valid_o <= 1'b1;
        end
        ST_RUN: begin
          if (!bad) begin
            pc_q       <= next_pc;
            if_valid_o <= 1'b1;
          end else begin
            st         <= ST_FAULT;
            if_valid_o <= 1'b0;
            fault_o    <= 1'b1;
            fault_pc_o <= next_pc;
          end
        end
        ST_FAULT: begin
          st <= ST_FAULT;
        end
        default: begin
          st         <= ST_PRIME;
          if_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: behavioural ROM, directed and random fetch traffic,
// expected outputs queued by a reference model and popped by a negedge monitor.
module tb_if_fetch_stage;

  localparam int DL = 9;

  logic          clk = 1'b0;
  logic          resetb;
  logic          stall_i;
  logic          redirect_i;
  logic [31:0]   redirect_pc_i;
  logic [DL-1:0] rom_addr_o;
  logic [31:0]   rom_data_i;
  logic          if_valid_o;
  logic [31:0]   if_pc_o;
  logic [31:0]   if_instr_o;
  logic          fault_o;
  logic [31:0]   fault_pc_o;
  logic [1:0]    dbg_state_o;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        f;
    logic [31:0] fpc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic        m_primed, m_valid, m_fault;
  logic [31:0] m_pc, m_fpc;

  logic [31:0] rom [0:(1<<DL)-1];

  if_fetch_stage #(.DEPTH_LOG(DL), .RESET_PC(32'h0)) dut (
    .clk(clk), .resetb(resetb), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_instr_o(if_instr_o),
    .fault_o(fault_o), .fault_pc_o(fault_pc_o), .dbg_state_o(dbg_state_o)
  );

  // clock / ROM
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < (1 << DL); i++) rom[i] = 32'hA000_0000 + i;
  end

  always @(posedge clk) rom_data_i <= rom[rom_addr_o];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: one clock edge with the given inputs
  task automatic step(input logic s, input logic r, input logic [31:0] rpc);
    logic [31:0] tgt;
    logic        is_bad;
    exp_t        e;
    stall_i = s; redirect_i = r; redirect_pc_i = rpc;
    @(posedge clk);
    #1;
    if (r) begin
      tgt    = rpc;
      is_bad = (tgt % 4 != 0) || (tgt >= 32'd2048);
      m_primed = 1'b1;
      if (!is_bad) begin
        m_pc = tgt; m_valid = 1'b1; m_fault = 1'b0;
      end else begin
        m_valid = 1'b0; m_fault = 1'b1; m_fpc = tgt;
      end
    end else if (!m_primed) begin
      m_primed = 1'b1; m_valid = 1'b1;
    end else if (!m_fault) begin
      tgt    = s ? m_pc : m_pc + 32'd4;
      is_bad = (tgt % 4 != 0) || (tgt >= 32'd2048);
      if (!is_bad) begin
        m_pc = tgt; m_valid = 1'b1;
      end else begin
        m_valid = 1'b0; m_fault = 1'b1; m_fpc = tgt;
      end
    end
    e.v = m_valid; e.pc = m_pc; e.instr = 32'hA000_0000 + (m_pc >> 2);
    e.f = m_fault; e.fpc = m_fpc;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_primed = 1'b0; m_valid = 1'b0; m_fault = 1'b0; m_pc = 32'h0; m_fpc = 32'h0;
  endtask

  // monitor
  always @(negedge clk) begin
    if (resetb === 1'b1 && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("valid", {31'h0, if_valid_o}, {31'h0, e.v});
      check("pc", if_pc_o, e.pc);
      check("fault", {31'h0, fault_o}, {31'h0, e.f});
      check("fault_pc", fault_pc_o, e.fpc);
      if (e.v) check("instr", if_instr_o, e.instr);
    end
  end

  task automatic reset_checks(input string tag);
    #1;
    check({tag, "_valid"}, {31'h0, if_valid_o}, 32'h0);
    check({tag, "_fault"}, {31'h0, fault_o}, 32'h0);
    check({tag, "_fault_pc"}, fault_pc_o, 32'h0);
    check({tag, "_rom_addr"}, {23'h0, rom_addr_o}, 32'h0);
  endtask

  function automatic logic [31:0] rand_target();
    int k;
    k = $urandom_range(0, 9);
    if (k < 7)       return {21'h0, 9'($urandom_range(0, 511)), 2'b00};
    else if (k == 7) return 32'h7F0 + {$urandom_range(0, 3), 2'b00};
    else if (k == 8) return {21'h0, 9'($urandom_range(0, 511)), 2'($urandom_range(1, 3))};
    else             return 32'h800 + $urandom;
  endfunction

  initial begin
    int waited;
    resetb = 1'b0; stall_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h100;
    model_reset();
    #3;
    reset_checks("rst0");
    redirect_i = 1'b0;
    @(negedge clk); #2; resetb = 1'b1;

    repeat (3) step(0, 0, 0);
    repeat (3) step(1, 0, 0);
    step(0, 0, 0);
    step(1, 1, 32'h100);
    step(0, 0, 0);
    step(0, 1, 32'h102);
    step(1, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 1, 32'h10);
    step(0, 0, 0);
    step(0, 1, 32'h7FC);
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 1, 32'h20);

    for (int i = 0; i < 1500; i++) begin
      logic s, r;
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 7) == 0);
      step(s, r, r ? rand_target() : $urandom);
    end

    // asynchronous reset between edges, with a redirect pending
    @(negedge clk); #2;
    redirect_i = 1'b1; redirect_pc_i = 32'h104;
    resetb = 1'b0;
    model_reset();
    reset_checks("rst_mid");
    @(posedge clk); #1;
    reset_checks("rst_hold");
    redirect_i = 1'b0;
    @(negedge clk); #2; resetb = 1'b1;
    repeat (3) step(0, 0, 0);
    for (int i = 0; i < 200; i++) step($urandom_range(0, 1) == 1, 1'b0, 32'h0);

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    n_cmp++;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
